decode_stage_pipe: RTL
======================

Name: decode_stage_pipe

Overview:
Parametrised, pipelined successor to the combinational decode block of the 16-bit core. Contains the architectural register file (1 write and 2 read ports) and the immediate/jump/shift field extractors. Detects load-use hazards and registers everything into the ID/EX pipeline register with valid, stall and flush control. Sits between the IF/ID register and the execute stage.

Parameters:
DATA_WIDTH, 16, register/datapath width; immediates are extended to this width (must be >= 16)
NUM_REGS, 8, register count (power of 2, >= 8); REG_IDX_W = $clog2(NUM_REGS)
JUMP_SHIFT, 1, left shift applied to the jump displacement (1 = word-aligned)

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
if_valid  input  1  instruction input is valid
instruction  input  16  encoded instruction from IF/ID
pc_plus2  input  DATA_WIDTH  PC+2 of the instruction
wb_en  input  1  register-file write enable
wb_idx  input  REG_IDX_W  write index
wb_data  input  DATA_WIDTH  write data
ex_mem_read  input  1  instruction currently in EX is a load
ex_rd  input  REG_IDX_W  destination register of the instruction in EX
stall_in  input  1  downstream stall; hold the ID/EX register
flush  input  1  squash the instruction in decode
hazard_stall  output  1  combinational; IF and IF/ID must hold
id_valid  output  1  ID/EX contents valid
read_data_1  output  DATA_WIDTH  RF[rs]
read_data_2  output  DATA_WIDTH  RF[rt]
rs_idx, rt_idx  output  REG_IDX_W  registered source indices
i_1  output  DATA_WIDTH  sext(instruction[4:0])
i_2  output  DATA_WIDTH  sext(instruction[7:0])
word_align_jump  output  DATA_WIDTH  sext(instruction[10:0]) << JUMP_SHIFT
to_shift  output  DATA_WIDTH  zext(instruction[3:0])
pc_plus2_q  output  DATA_WIDTH  registered pc_plus2

Behaviour:
- Fields: rs = instruction[10:8], rt = instruction[7:5], zero-extended to REG_IDX_W. Register indices >= 8 are reachable only through wb_idx.
- Reset (async, rst_n low): all RF entries = 0; id_valid = 0; every ID/EX output = 0. When rst_n is released, the first capture happens on the next rising edge.
- Latency: one cycle. An instruction presented at edge N appears on the outputs after edge N.
- RF write: on a rising edge when wb_en is 1, RF[wb_idx] <= wb_data. All registers are writable, including R0.
- hazard_stall = if_valid & ex_mem_read & ((rs == ex_rd) | (rt == ex_rd)). The stage keeps no history; the caller gates ex_mem_read with EX validity.
- ID/EX update priority at each edge:
  1. flush: id_valid <= 0, data outputs hold. Wins over stall_in.
  2. stall_in: all ID/EX outputs hold, including id_valid.
  3. hazard_stall: bubble; id_valid <= 0, data outputs hold.
  4. otherwise: capture decoded fields; id_valid <= if_valid.
- hazard_stall is still driven while stall_in is 1. Upstream holds for either cause.
- No arithmetic overflow is possible. Extension uses bit replication only.
- Reset mid-operation: any in-flight instruction is discarded, and the RF contents are lost (zeroed).

Optional Feature:
Macro DECODE_WB_BYPASS_EN.
- Defined: if wb_en is 1 and wb_idx equals rs (or rt) in the same cycle as a capture, the captured read data is wb_data (write-through bypass).
- Undefined: the capture takes the old RF value; the core relies on forwarding elsewhere.
- Hazard logic is identical in both builds.

Test Plan:
1. Reset, then if_valid=1, instruction=16'h2001, pc_plus2=16'h0002, no WB. After 1 edge: id_valid=1, i_1=16'h0001, i_2=16'h0001, word_align_jump=16'h0002, to_shift=16'h0001, read_data_1=read_data_2=0.
2. wb_en=1, wb_idx=0, wb_data=16'hBEEF for one edge; next edge decode 16'b0101100000010000 (rs=0, rt=0). read_data_1 = 16'hBEEF; i_2 = 16'h0010; word_align_jump = 16'h0020.
3. Same-cycle write: wb_idx=3, wb_data=16'h1234, instruction rs=3. With DECODE_WB_BYPASS_EN: read_data_1=16'h1234. Without it: old value 0.
4. ex_mem_read=1, ex_rd=2, instruction rt=2, if_valid=1 -> hazard_stall=1 combinationally; after edge id_valid=0. Drop ex_mem_read -> capture on the next edge, id_valid=1.
5. stall_in=1 with a new instruction -> all outputs unchanged. Assert flush and stall_in together -> id_valid=0.
6. Instruction 16'h07FF (jump field 11'h7FF) -> word_align_jump=16'hFFFE; 16'h0010 -> i_1=16'hFFF0. Assert rst_n=0 between edges -> id_valid and all outputs 0 immediately.

Source files
------------

// File: rtl/decode_stage_pipe.sv
// Decode stage: architectural register file, immediate/jump/shift extraction,
// load-use hazard detection and the ID/EX pipeline register.
// Optional write-through bypass on capture: define DECODE_WB_BYPASS_EN.
module decode_stage_pipe #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_REGS   = 8,
  parameter int JUMP_SHIFT = 1,
  localparam int REG_IDX_W = $clog2(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  if_valid,
  input  logic [15:0]           instruction,
  input  logic [DATA_WIDTH-1:0] pc_plus2,
  input  logic                  wb_en,
  input  logic [REG_IDX_W-1:0]  wb_idx,
  input  logic [DATA_WIDTH-1:0] wb_data,
  input  logic                  ex_mem_read,
  input  logic [REG_IDX_W-1:0]  ex_rd,
  input  logic                  stall_in,
  input  logic                  flush,
  output logic                  hazard_stall,
  output logic                  id_valid,
  output logic [DATA_WIDTH-1:0] read_data_1,
  output logic [DATA_WIDTH-1:0] read_data_2,
  output logic [REG_IDX_W-1:0]  rs_idx,
  output logic [REG_IDX_W-1:0]  rt_idx,
  output logic [DATA_WIDTH-1:0] i_1,
  output logic [DATA_WIDTH-1:0] i_2,
  output logic [DATA_WIDTH-1:0] word_align_jump,
  output logic [DATA_WIDTH-1:0] to_shift,
  output logic [DATA_WIDTH-1:0] pc_plus2_q
);

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

  logic [REG_IDX_W-1:0]  rs_dec;
  logic [REG_IDX_W-1:0]  rt_dec;
  logic [DATA_WIDTH-1:0] imm5_ext;
  logic [DATA_WIDTH-1:0] imm8_ext;
  logic [DATA_WIDTH-1:0] jump_ext;
  logic [DATA_WIDTH-1:0] shamt_ext;
  logic [DATA_WIDTH-1:0] rf_rd1;
  logic [DATA_WIDTH-1:0] rf_rd2;
  logic [DATA_WIDTH-1:0] src_rd1;
  logic [DATA_WIDTH-1:0] src_rd2;
  logic                  src_hit_rd1;
  logic                  src_hit_rd2;
  logic                  unused_opcode;

  logic                  id_valid_q, id_valid_d;
  logic [DATA_WIDTH-1:0] rd1_q, rd1_d;
  logic [DATA_WIDTH-1:0] rd2_q, rd2_d;
  logic [REG_IDX_W-1:0]  rs_q, rs_d;
  logic [REG_IDX_W-1:0]  rt_q, rt_d;
  logic [DATA_WIDTH-1:0] i1_q, i1_d;
  logic [DATA_WIDTH-1:0] i2_q, i2_d;
  logic [DATA_WIDTH-1:0] jump_q, jump_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;

  // Opcode bits are consumed by the execute-side control decoder, not here.
  assign unused_opcode = ^instruction[15:11];

  always_comb begin
    rs_dec    = REG_IDX_W'(instruction[10:8]);
    rt_dec    = REG_IDX_W'(instruction[7:5]);
    imm5_ext  = {{(DATA_WIDTH-5){instruction[4]}}, instruction[4:0]};
    imm8_ext  = {{(DATA_WIDTH-8){instruction[7]}}, instruction[7:0]};
    jump_ext  = {{(DATA_WIDTH-11){instruction[10]}}, instruction[10:0]} << JUMP_SHIFT;
    shamt_ext = {{(DATA_WIDTH-4){1'b0}}, instruction[3:0]};
  end

  always_comb begin
    regs_d = regs_q;
    if (wb_en) begin
      regs_d[wb_idx] = wb_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  assign rf_rd1 = regs_q[rs_dec];
  assign rf_rd2 = regs_q[rt_dec];

`ifdef DECODE_WB_BYPASS_EN
  // A write landing on the same edge as the capture is forwarded into ID/EX.
  assign src_hit_rd1 = wb_en && (wb_idx == rs_dec);
  assign src_hit_rd2 = wb_en && (wb_idx == rt_dec);
`else
  assign src_hit_rd1 = 1'b0;
  assign src_hit_rd2 = 1'b0;
`endif

  assign src_rd1 = src_hit_rd1 ? wb_data : rf_rd1;
  assign src_rd2 = src_hit_rd2 ? wb_data : rf_rd2;

  // ex_mem_read is assumed already qualified by EX validity upstream.
  assign hazard_stall = if_valid && ex_mem_read &&
                        ((rs_dec == ex_rd) || (rt_dec == ex_rd));

  always_comb begin
    id_valid_d = id_valid_q;
    rd1_d      = rd1_q;
    rd2_d      = rd2_q;
    rs_d       = rs_q;
    rt_d       = rt_q;
    i1_d       = i1_q;
    i2_d       = i2_q;
    jump_d     = jump_q;
    shift_d    = shift_q;
    pc_d       = pc_q;
    if (flush) begin
      id_valid_d = 1'b0;
    end else if (!stall_in) begin
      if (hazard_stall) begin
        id_valid_d = 1'b0;
      end else begin
        id_valid_d = if_valid;
        rd1_d      = src_rd1;
        rd2_d      = src_rd2;
        rs_d       = rs_dec;
        rt_d       = rt_dec;
        i1_d       = imm5_ext;
        i2_d       = imm8_ext;
        jump_d     = jump_ext;
        shift_d    = shamt_ext;
        pc_d       = pc_plus2;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_valid_q <= 1'b0;
      rd1_q      <= '0;
      rd2_q      <= '0;
      rs_q       <= '0;
      rt_q       <= '0;
      i1_q       <= '0;
      i2_q       <= '0;
      jump_q     <= '0;
      shift_q    <= '0;
      pc_q       <= '0;
    end else begin
      id_valid_q <= id_valid_d;
      rd1_q      <= rd1_d;
      rd2_q      <= rd2_d;
      rs_q       <= rs_d;
      rt_q       <= rt_d;
      i1_q       <= i1_d;
      i2_q       <= i2_d;
      jump_q     <= jump_d;
      shift_q    <= shift_d;
      pc_q       <= pc_d;
    end
  end

  assign id_valid        = id_valid_q;
  assign read_data_1     = rd1_q;
  assign read_data_2     = rd2_q;
  assign rs_idx          = rs_q;
  assign rt_idx          = rt_q;
  assign i_1             = i1_q;
  assign i_2             = i2_q;
  assign word_align_jump = jump_q;
  assign to_shift        = shift_q;
  assign pc_plus2_q      = pc_q;

endmodule
